// File: rtl/golden_nonce_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_reader_if
// Purpose  : Bundles the miner-core nonce input, the host read port and the
//            status outputs of the golden nonce reader.
// Revision : 1.0 - initial release
// ============================================================================
interface golden_nonce_reader_if #(
  parameter int AW = 3
);
  logic [31:0] golden_nonce;
  logic        rd_strobe;
  logic        clr_ovf;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [AW:0] level;
  logic        overflow;

  // Miner core / host side: drives the nonce and read controls
  modport master (
    output golden_nonce, rd_strobe, clr_ovf,
    input  rd_data, rd_valid, level, overflow
  );

  // Reader side
  modport slave (
    input  golden_nonce, rd_strobe, clr_ovf,
    output rd_data, rd_valid, level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/golden_nonce_reader.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_reader
// Purpose  : Captures each new golden nonce from a miner core into a FIFO and
//            lets the host drain it one byte per read strobe, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_reader #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire logic             clk,
  input  wire logic             reset,   // asynchronous, active-low
  golden_nonce_reader_if.slave  bus
);

  localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [1:0]    c_LAST_B  = 2'd3;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_prev_gn;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [1:0]    r_byte_idx;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic          w_push;
  logic          w_valid;
  logic          w_full;
  logic          w_rd;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [31:0]   w_head;
  logic [7:0]    w_rd_byte;

  // A push is any change on the held nonce; a pop is the strobe on byte 3.
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_push  = (bus.golden_nonce != r_prev_gn);
  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == c_FULL);
  assign w_rd    = bus.rd_strobe & w_valid;
  assign w_pop   = w_rd & (r_byte_idx == c_LAST_B);
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rptr];

  // Select the current byte of the head entry; zero while empty
  always_comb begin
    w_rd_byte = 8'h00;
    if (w_valid) begin
      case (r_byte_idx)
        2'd0:    w_rd_byte = w_head[7:0];
        2'd1:    w_rd_byte = w_head[15:8];
        2'd2:    w_rd_byte = w_head[23:16];
        default: w_rd_byte = w_head[31:24];
      endcase
    end
  end

  assign bus.rd_data  = w_rd_byte;
  assign bus.rd_valid = w_valid;
  assign bus.level    = r_level;
  assign bus.overflow = r_overflow;

  // Storage array; contents are only observable through level, so no reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= bus.golden_nonce;
    end
  end

  // Change detector, pointers, byte cursor, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_gn  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_byte_idx <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_gn <= bus.golden_nonce;

      if (w_wr) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end

      if (w_rd) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end

      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase

      // Set has priority over clear so a drop is never lost
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_golden_nonce_reader
// Purpose  : Directed self-checking bench for golden_nonce_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_reader;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  golden_nonce_reader_if #(.AW(AW)) bus ();

  golden_nonce_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the presented byte, strobe it in on the next edge (strobe left high)
  task automatic rd_byte(input string tag, input logic [7:0] exp);
    bus.rd_strobe = 1'b1;
    chk(tag, {24'h0, bus.rd_data}, {24'h0, exp});
    step();
  endtask

  task automatic rd_word(input string tag, input logic [31:0] exp);
    rd_byte(tag, exp[7:0]);
    rd_byte(tag, exp[15:8]);
    rd_byte(tag, exp[23:16]);
    rd_byte(tag, exp[31:24]);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.golden_nonce = 32'h0;
    bus.rd_strobe    = 1'b0;
    bus.clr_ovf      = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // 1: idle after reset with a zero nonce
    repeat (20) step();
    chk("t1_valid", {31'h0, bus.rd_valid}, 32'h0);
    chk("t1_level", {28'h0, bus.level}, 32'h0);
    chk("t1_data",  {24'h0, bus.rd_data}, 32'h0);
    chk("t1_ovf",   {31'h0, bus.overflow}, 32'h0);

    // 2: one held value pushes once
    bus.golden_nonce = 32'h12345678;
    step();
    chk("t2_latency", {28'h0, bus.level}, 32'd1);
    repeat (9) step();
    chk("t2_level", {28'h0, bus.level}, 32'd1);
    rd_word("t2_rd", 32'h12345678);
    bus.rd_strobe = 1'b0;
    chk("t2_valid", {31'h0, bus.rd_valid}, 32'h0);
    chk("t2_level0", {28'h0, bus.level}, 32'd0);

    // 3: back-to-back values, continuous drain
    bus.golden_nonce = 32'hA1; step();
    bus.golden_nonce = 32'hB2; step();
    bus.golden_nonce = 32'hC3; step();
    chk("t3_level", {28'h0, bus.level}, 32'd3);
    rd_word("t3_rdA", 32'hA1);
    rd_word("t3_rdB", 32'hB2);
    rd_word("t3_rdC", 32'hC3);
    bus.rd_strobe = 1'b0;
    chk("t3_level0", {28'h0, bus.level}, 32'd0);

    // 4: overflow on the ninth value
    for (int i = 0; i < 9; i++) begin
      bus.golden_nonce = 32'h100 + i;
      step();
    end
    chk("t4_level", {28'h0, bus.level}, 32'd8);
    chk("t4_ovf",   {31'h0, bus.overflow}, 32'h1);
    for (int i = 0; i < 8; i++) rd_word("t4_rd", 32'h100 + i);
    bus.rd_strobe = 1'b0;
    chk("t4_empty", {31'h0, bus.rd_valid}, 32'h0);
    chk("t4_ovf_hold", {31'h0, bus.overflow}, 32'h1);
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    chk("t4_clr", {31'h0, bus.overflow}, 32'h0);

    // 5: push accepted while full thanks to a same-cycle pop
    for (int i = 0; i < 8; i++) begin
      bus.golden_nonce = 32'h200 + i;
      step();
    end
    chk("t5_full", {28'h0, bus.level}, 32'd8);
    rd_byte("t5_b0", 8'h00);
    rd_byte("t5_b1", 8'h02);
    rd_byte("t5_b2", 8'h00);
    bus.golden_nonce = 32'hCAFEF00D;
    rd_byte("t5_b3", 8'h00);
    bus.rd_strobe = 1'b0;
    chk("t5_level", {28'h0, bus.level}, 32'd8);
    chk("t5_ovf",   {31'h0, bus.overflow}, 32'h0);
    // drop and clear in one cycle: the drop wins
    bus.golden_nonce = 32'h55;
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    chk("t5_setwins", {31'h0, bus.overflow}, 32'h1);
    chk("t5_lvl_drop", {28'h0, bus.level}, 32'd8);
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    chk("t5_clr", {31'h0, bus.overflow}, 32'h0);
    for (int i = 1; i < 8; i++) rd_word("t5_rd", 32'h200 + i);
    rd_word("t5_new", 32'hCAFEF00D);
    bus.rd_strobe = 1'b0;
    chk("t5_empty", {28'h0, bus.level}, 32'd0);

    // strobe together with a push into an empty FIFO is ignored
    bus.golden_nonce = 32'h77;
    bus.rd_strobe = 1'b1; step(); bus.rd_strobe = 1'b0;
    chk("t5b_level", {28'h0, bus.level}, 32'd1);
    rd_word("t5b_rd", 32'h77);
    bus.rd_strobe = 1'b0;
    chk("t5b_empty", {31'h0, bus.rd_valid}, 32'h0);

    // 6: reset in the middle of a partial read
    bus.golden_nonce = 32'hDEADBEEF;
    step();
    rd_byte("t6_b0", 8'hEF);
    rd_byte("t6_b1", 8'hBE);
    bus.rd_strobe = 1'b0;
    bus.golden_nonce = 32'h01020304;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", {28'h0, bus.level}, 32'd0);
    chk("t6_rst_valid", {31'h0, bus.rd_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_level", {28'h0, bus.level}, 32'd1);
    rd_word("t6_rd", 32'h01020304);
    bus.rd_strobe = 1'b0;
    chk("t6_empty", {28'h0, bus.level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
